// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode/operand stage.
// Decodes the fetched instruction, selects forwarded operands and registers the
// result into the ID/EX pipeline register with a valid/ready handshake.
module id_ex_stage #(
   parameter int XLEN       = 32,
   parameter int FWD_ENABLE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            fwd_ex_we,
   input  logic [4:0]      fwd_ex_rd,
   input  logic [XLEN-1:0] fwd_ex_data,
   input  logic            fwd_wb_we,
   input  logic [4:0]      fwd_wb_rd,
   input  logic [XLEN-1:0] fwd_wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] operand_a,
   output logic [XLEN-1:0] operand_b,
   output logic [3:0]      alu_control,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            mem_read,
   output logic            mem_write,
   output logic [XLEN-1:0] store_data,
   output logic            is_branch,
   output logic            branch_invert,
   output logic            is_jump,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] imm_out,
   output logic            illegal
);

   localparam logic [3:0] ALU_AND  = 4'b0000, ALU_OR  = 4'b0001, ALU_XOR = 4'b0010,
                          ALU_ADD  = 4'b0011, ALU_SUB = 4'b0100, ALU_SLL = 4'b0101,
                          ALU_SRL  = 4'b0110, ALU_SRA = 4'b0111, ALU_SLT = 4'b1000,
                          ALU_SLTU = 4'b1001, ALU_BEQ = 4'b1010, ALU_BNE = 4'b1011;

   localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL   = 7'b1101111,
                          OPC_JALR = 7'b1100111, OPC_BRANCH = 7'b1100011, OPC_LOAD = 7'b0000011,
                          OPC_STORE = 7'b0100011, OPC_IMM  = 7'b0010011, OPC_OP    = 7'b0110011;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd_field;
   logic       load;

   assign opcode   = instr[6:0];
   assign funct3   = instr[14:12];
   assign funct7   = instr[31:25];
   assign rd_field = instr[11:7];
   assign in_ready = out_ready | ~out_valid;
   assign load     = in_valid & in_ready;

   // Immediates, all sign-extended from instr[31]; shift amount zero-extended.
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
   assign imm_i = XLEN'($signed(instr[31:20]));
   assign imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
   assign imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({instr[31:12], 12'b0}));
   assign imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
   assign shamt = XLEN'(instr[24:20]);

   // Operand forwarding for both sources: x0 reads zero, EX/MEM wins over MEM/WB.
   logic [4:0]      rs_idx [2];
   logic [XLEN-1:0] rs_raw [2];
   logic [XLEN-1:0] rs_fwd [2];
   assign rs_idx[0] = instr[19:15];
   assign rs_idx[1] = instr[24:20];
   assign rs_raw[0] = rs1_data;
   assign rs_raw[1] = rs2_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         assign rs_fwd[gi] =
            (rs_idx[gi] == 5'd0) ? '0 :
            ((FWD_ENABLE != 0) && fwd_ex_we && (fwd_ex_rd == rs_idx[gi])) ? fwd_ex_data :
            ((FWD_ENABLE != 0) && fwd_wb_we && (fwd_wb_rd == rs_idx[gi])) ? fwd_wb_data :
            rs_raw[gi];
      end
   endgenerate

   logic [3:0]      alu_next;
   logic [XLEN-1:0] a_next, b_next, sd_next, imm_next;
   logic [4:0]      rd_next;
   logic            rw_next, mr_next, mw_next, br_next, inv_next, jmp_next, ill_next;

   // Instruction decode into the next ID/EX register contents.
   always_comb begin
      alu_next = ALU_ADD;
      a_next   = '0;
      b_next   = '0;
      sd_next  = '0;
      imm_next = '0;
      rd_next  = 5'd0;
      rw_next  = 1'b0;
      mr_next  = 1'b0;
      mw_next  = 1'b0;
      br_next  = 1'b0;
      inv_next = 1'b0;
      jmp_next = 1'b0;
      ill_next = 1'b0;
      case (opcode)
         OPC_LUI: begin
            b_next = imm_u; imm_next = imm_u; rd_next = rd_field; rw_next = 1'b1;
         end
         OPC_AUIPC: begin
            a_next = pc; b_next = imm_u; imm_next = imm_u; rd_next = rd_field; rw_next = 1'b1;
         end
         OPC_JAL: begin
            a_next = pc; b_next = XLEN'(4); imm_next = imm_j; jmp_next = 1'b1;
            rd_next = rd_field; rw_next = 1'b1;
         end
         OPC_JALR: begin
            // Link value pc+4 goes through the ALU; imm_out carries the target offset.
            a_next = pc; b_next = XLEN'(4); imm_next = imm_i; jmp_next = 1'b1;
            rd_next = rd_field; rw_next = 1'b1;
            ill_next = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            a_next = rs_fwd[0]; b_next = rs_fwd[1]; imm_next = imm_b; br_next = 1'b1;
            case (funct3)
               3'b000:  alu_next = ALU_BEQ;
               3'b001:  alu_next = ALU_BNE;
               3'b100:  alu_next = ALU_SLT;
               3'b101:  begin alu_next = ALU_SLT;  inv_next = 1'b1; end
               3'b110:  alu_next = ALU_SLTU;
               3'b111:  begin alu_next = ALU_SLTU; inv_next = 1'b1; end
               default: ill_next = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            a_next = rs_fwd[0]; b_next = imm_i; imm_next = imm_i; mr_next = 1'b1;
            rd_next = rd_field; rw_next = 1'b1;
            ill_next = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
         end
         OPC_STORE: begin
            a_next = rs_fwd[0]; b_next = imm_s; imm_next = imm_s; mw_next = 1'b1;
            sd_next = rs_fwd[1];
            ill_next = (funct3[2] || (funct3[1:0] == 2'b11));
         end
         OPC_IMM: begin
            a_next = rs_fwd[0]; b_next = imm_i; imm_next = imm_i; rd_next = rd_field; rw_next = 1'b1;
            case (funct3)
               3'b000:  alu_next = ALU_ADD;
               3'b010:  alu_next = ALU_SLT;
               3'b011:  alu_next = ALU_SLTU;
               3'b100:  alu_next = ALU_XOR;
               3'b110:  alu_next = ALU_OR;
               3'b111:  alu_next = ALU_AND;
               3'b001: begin
                  alu_next = ALU_SLL; b_next = shamt;
                  ill_next = (funct7 != 7'b0000000);
               end
               default: begin
                  alu_next = instr[30] ? ALU_SRA : ALU_SRL; b_next = shamt;
                  ill_next = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
               end
            endcase
         end
         OPC_OP: begin
            a_next = rs_fwd[0]; b_next = rs_fwd[1]; rd_next = rd_field; rw_next = 1'b1;
            case (funct3)
               3'b000:  alu_next = instr[30] ? ALU_SUB : ALU_ADD;
               3'b001:  alu_next = ALU_SLL;
               3'b010:  alu_next = ALU_SLT;
               3'b011:  alu_next = ALU_SLTU;
               3'b100:  alu_next = ALU_XOR;
               3'b101:  alu_next = instr[30] ? ALU_SRA : ALU_SRL;
               3'b110:  alu_next = ALU_OR;
               default: alu_next = ALU_AND;
            endcase
            // Only ADD/SUB and SRL/SRA have a funct7=0100000 variant.
            ill_next = !((funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
         end
         default: ill_next = 1'b1;
      endcase
      if (rd_next == 5'd0)
         rw_next = 1'b0;
      // Illegal instructions travel as a harmless ADD 0+0 with every side effect off.
      if (ill_next) begin
         alu_next = ALU_ADD; a_next = '0; b_next = '0; sd_next = '0; imm_next = '0;
         rd_next = 5'd0; rw_next = 1'b0; mr_next = 1'b0; mw_next = 1'b0;
         br_next = 1'b0; inv_next = 1'b0; jmp_next = 1'b0;
      end
   end

   // ID/EX pipeline register: reset/flush clear, load on handshake, else hold or drain.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid     <= 1'b0;
         operand_a     <= '0;
         operand_b     <= '0;
         alu_control   <= 4'b0000;
         rd            <= 5'd0;
         reg_write     <= 1'b0;
         mem_read      <= 1'b0;
         mem_write     <= 1'b0;
         store_data    <= '0;
         is_branch     <= 1'b0;
         branch_invert <= 1'b0;
         is_jump       <= 1'b0;
         pc_out        <= '0;
         imm_out       <= '0;
         illegal       <= 1'b0;
      end else if (load) begin
         out_valid     <= 1'b1;
         operand_a     <= a_next;
         operand_b     <= b_next;
         alu_control   <= alu_next;
         rd            <= rd_next;
         reg_write     <= rw_next;
         mem_read      <= mr_next;
         mem_write     <= mw_next;
         store_data    <= sd_next;
         is_branch     <= br_next;
         branch_invert <= inv_next;
         is_jump       <= jmp_next;
         pc_out        <= pc;
         imm_out       <= imm_next;
         illegal       <= ill_next;
      end else if (out_ready) begin
         out_valid     <= 1'b0;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with hand-computed expectations for id_ex_stage.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] instr, pc, rs1_data, rs2_data;
   logic        fwd_ex_we, fwd_wb_we;
   logic [4:0]  fwd_ex_rd, fwd_wb_rd, rd;
   logic [31:0] fwd_ex_data, fwd_wb_data;
   logic [31:0] operand_a, operand_b, store_data, pc_out, imm_out;
   logic [3:0]  alu_control;
   logic        reg_write, mem_read, mem_write, is_branch, branch_invert, is_jump, illegal;

   int n_vec = 0;
   int n_err = 0;

   id_ex_stage #(.XLEN(32), .FWD_ENABLE(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
      .fwd_ex_we(fwd_ex_we), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_data(fwd_ex_data),
      .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .operand_a(operand_a), .operand_b(operand_b), .alu_control(alu_control),
      .rd(rd), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
      .store_data(store_data), .is_branch(is_branch), .branch_invert(branch_invert),
      .is_jump(is_jump), .pc_out(pc_out), .imm_out(imm_out), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] i, input logic [31:0] p,
                        input logic [31:0] r1, input logic [31:0] r2);
      in_valid = 1'b1; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
      fwd_ex_we = 1'b0; fwd_ex_rd = 5'd0; fwd_ex_data = 32'h0;
      fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'h0;
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_alu",   32'(alu_control), 32'h0);
      chk("rst_a",     operand_a, 32'h0);
      chk("rst_rw",    32'(reg_write), 32'h0);
      chk("rst_ready", 32'(in_ready), 32'h1);
      rst = 1'b0;

      // addi x1,x0,5
      drive(32'h00500093, 32'h100, 32'h0, 32'h0); step();
      chk("addi_valid", 32'(out_valid), 32'h1);
      chk("addi_alu",   32'(alu_control), 32'h3);
      chk("addi_a",     operand_a, 32'h0);
      chk("addi_b",     operand_b, 32'h5);
      chk("addi_rd",    32'(rd), 32'h1);
      chk("addi_rw",    32'(reg_write), 32'h1);
      chk("addi_pc",    pc_out, 32'h100);

      // sub x2,x1,x2 from the register file
      drive(32'h40208133, 32'h104, 32'h7, 32'h3); step();
      chk("sub_alu", 32'(alu_control), 32'h4);
      chk("sub_a",   operand_a, 32'h7);
      chk("sub_b",   operand_b, 32'h3);
      chk("sub_rd",  32'(rd), 32'h2);

      // forwarding: EX match beats WB match, then WB alone
      fwd_ex_we = 1'b1; fwd_ex_rd = 5'd1; fwd_ex_data = 32'h1234;
      fwd_wb_we = 1'b1; fwd_wb_rd = 5'd1; fwd_wb_data = 32'h5678;
      step();
      chk("fwd_ex_a", operand_a, 32'h1234);
      chk("fwd_ex_b", operand_b, 32'h3);
      fwd_ex_we = 1'b0; step();
      chk("fwd_wb_a", operand_a, 32'h5678);
      fwd_wb_we = 1'b0;

      // bge x1,x2
      drive(32'h0020D063, 32'h108, 32'h10, 32'h20); step();
      chk("bge_alu", 32'(alu_control), 32'h8);
      chk("bge_inv", 32'(branch_invert), 32'h1);
      chk("bge_br",  32'(is_branch), 32'h1);
      chk("bge_rw",  32'(reg_write), 32'h0);
      chk("bge_a",   operand_a, 32'h10);
      chk("bge_b",   operand_b, 32'h20);

      // addi x0,x0,1: write to x0 suppressed
      drive(32'h00100013, 32'h10C, 32'h0, 32'h0); step();
      chk("x0_rw", 32'(reg_write), 32'h0);

      // lui x1,0x12345
      drive(32'h123450B7, 32'h110, 32'hFFFF, 32'h0); step();
      chk("lui_a", operand_a, 32'h0);
      chk("lui_b", operand_b, 32'h12345000);

      // auipc x5,1
      drive(32'h00001297, 32'h200, 32'h0, 32'h0); step();
      chk("auipc_a",  operand_a, 32'h200);
      chk("auipc_b",  operand_b, 32'h1000);
      chk("auipc_rd", 32'(rd), 32'h5);

      // jal x1,8
      drive(32'h008000EF, 32'h300, 32'h0, 32'h0); step();
      chk("jal_a",   operand_a, 32'h300);
      chk("jal_b",   operand_b, 32'h4);
      chk("jal_imm", imm_out, 32'h8);
      chk("jal_j",   32'(is_jump), 32'h1);

      // sw x2,4(x1)
      drive(32'h0020A223, 32'h304, 32'h1000, 32'hCAFEBABE); step();
      chk("sw_a",  operand_a, 32'h1000);
      chk("sw_b",  operand_b, 32'h4);
      chk("sw_mw", 32'(mem_write), 32'h1);
      chk("sw_rw", 32'(reg_write), 32'h0);
      chk("sw_sd", store_data, 32'hCAFEBABE);

      // srai x3,x1,3
      drive(32'h4030D193, 32'h308, 32'h80000000, 32'h0); step();
      chk("srai_alu", 32'(alu_control), 32'h7);
      chk("srai_b",   operand_b, 32'h3);
      chk("srai_a",   operand_a, 32'h80000000);

      // addi x1,x0,-1: sign extension
      drive(32'hFFF00093, 32'h30C, 32'h0, 32'h0); step();
      chk("neg_b", operand_b, 32'hFFFFFFFF);

      // stall: hold lui while execute is busy
      drive(32'h123450B7, 32'h400, 32'h0, 32'h0); step();
      out_ready = 1'b0;
      drive(32'h00500093, 32'h404, 32'h0, 32'h0); #1;
      chk("stall_ready", 32'(in_ready), 32'h0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("stall_valid", 32'(out_valid), 32'h1);
         chk("stall_b",     operand_b, 32'h12345000);
         chk("stall_pc",    pc_out, 32'h400);
      end
      out_ready = 1'b1; #1;
      chk("unstall_ready", 32'(in_ready), 32'h1);
      step();
      chk("unstall_b",  operand_b, 32'h5);
      chk("unstall_pc", pc_out, 32'h404);

      // flush discards the beat accepted in the same cycle
      flush = 1'b1; step();
      chk("flush_valid", 32'(out_valid), 32'h0);
      flush = 1'b0;

      // illegal instruction
      drive(32'hFFFFFFFF, 32'h408, 32'h0, 32'h0); step();
      chk("ill_flag",  32'(illegal), 32'h1);
      chk("ill_rw",    32'(reg_write), 32'h0);
      chk("ill_valid", 32'(out_valid), 32'h1);
      chk("ill_alu",   32'(alu_control), 32'h3);

      // drain: consumed with nothing behind it
      in_valid = 1'b0; step();
      chk("drain_valid", 32'(out_valid), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
